instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Front-end fetch stage that sits directly upstream of the CPU decoder.
- Reads instruction bytes over a byte-wide memory handshake and assembles one complete SM83 instruction per transfer: the opcode, the CB-prefix flag and the 0/1/2 operand bytes.
- Presents each assembled instruction to the decoder with a valid/ready handshake.
- Owns the program counter and accepts redirects from branch/call/return/interrupt logic.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (boot ROM entry).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- mem_addr  out  16  byte address of the current read.
- mem_rd  out  1  read request; held with a stable mem_addr until acked.
- mem_rdata  in  8  read data, valid when mem_ack=1.
- mem_ack  in  1  read complete; the byte is captured on the edge where mem_rd&&mem_ack.
- pc_load  in  1  redirect pulse.
- pc_load_val  in  16  redirect target.
- halt  in  1  level; while high, no new instruction fetch is started.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  downstream accepts the instruction.
- opcode  out  8  opcode byte; for CB-prefixed instructions, the byte after CB.
- cb_prefix  out  1  the instruction was CB-prefixed.
- imm  out  16  operands: {hi,lo}; for 1 operand, {8'h00,lo}; for none, 0.
- imm_len  out  2  operand byte count, 0/1/2.
- illegal  out  1  opcode is D3,DB,DD,E3,E4,EB,EC,ED,F4,FC or FD (unprefixed only).
- instr_pc  out  16  address of the instruction's first byte.
- next_pc  out  16  address following the last byte of the instruction.

Behaviour:
- Reset (async): PC=RESET_PC, state=OPC, mem_rd=0, mem_addr=RESET_PC. Outputs reset as: instr_valid=0, opcode=0, cb_prefix=0, imm=0, imm_len=0, illegal=0, instr_pc=RESET_PC, next_pc=RESET_PC.
- States: OPC, CBOP, LO, HI, HOLD.
  - OPC: mem_rd=!halt, mem_addr=PC. On ack:
    - instr_pc=PC, PC++.
    - If byte=CB: go to CBOP.
    - Else: latch the opcode and length, then go to LO if length≥2, otherwise HOLD.
  - CBOP: read PC; on ack, opcode=byte, cb_prefix=1, imm_len=0, PC++, go to HOLD.
  - LO: read PC; on ack, imm[7:0]=byte, PC++, go to HI if length=3, otherwise HOLD.
  - HI: read PC; on ack, imm[15:8]=byte, PC++, go to HOLD.
  - HOLD: instr_valid=1, mem_rd=0, next_pc=PC. On instr_ready, instr_valid drops and the state goes to OPC; the next fetch starts in the following cycle.
- Length table (unprefixed):
  - 2 bytes: 06,0E,16,1E,26,2E,36,3E; 10; 18,20,28,30,38; C6,CE,D6,DE,E6,EE,F6,FE; E0,F0,E8,F8.
  - 3 bytes: 01,11,21,31; 08; C2,C3,C4,CA,CC,CD,D2,D4,DA,DC; EA,FA.
  - CB counts as one prefix byte plus one opcode byte; all other opcodes are 1 byte.
- Minimum cost: 1 cycle per byte plus 1 HOLD cycle. With a zero-wait memory (ack in the same cycle as mem_rd), a 1-byte instruction is valid 1 cycle after its fetch starts and a 3-byte instruction after 3 cycles.
- Wait states: mem_addr and mem_rd stay stable until mem_ack; nothing is captured without mem_ack.
- PC arithmetic is 16-bit modulo; 16'hFFFF + 1 = 16'h0000, including inside a multi-byte instruction.
- Redirect: pc_load has the highest priority, in any state.
  - Next edge: PC=pc_load_val, instr_valid=0, state=OPC.
  - Any partly assembled instruction is discarded, and any ack in that same cycle is ignored.
  - A simultaneous instr_ready is ignored (the held instruction is dropped).
- Halt:
  - Halt only gates the start of a fetch in OPC.
  - A fetch already in progress (CBOP/LO/HI) completes.
  - A held instruction stays valid.
  - If halt rises in OPC while a request is already waiting on ack, mem_rd drops; no byte is captured.
- Illegal opcodes are passed through with illegal=1 and length 1; no special state.
- Output fields are stable for the whole period instr_valid=1.

Test Plan:
- Reset with RESET_PC=0, memory {00,3E,42,C3,34,12}, instr_ready=1, zero-wait -> first instruction: opcode=00, imm_len=0, instr_pc=0000, next_pc=0001. Second: opcode=3E, imm=0042, imm_len=1. Third: opcode=C3, imm=1234, imm_len=2, next_pc=0006.
- Bytes CB,37 at 0100 (after redirect to 0100) -> opcode=37, cb_prefix=1, imm_len=0, instr_pc=0100, next_pc=0102.
- Same program with 2 wait cycles per byte -> mem_addr held stable for 3 cycles per byte; C3 instruction valid 9 cycles after its fetch begins; contents identical to the zero-wait run.
- 3-byte CD at FFFE -> operands read from FFFF then 0000; next_pc=0001.
- pc_load=1 with pc_load_val=0200 during the HI wait of a 3-byte fetch -> no valid output; the next request is at 0200. A redirect while HOLD asserts instr_ready drops the held instruction.
- halt=1 in OPC -> mem_rd stays 0 indefinitely. Release -> fetch resumes at the unchanged PC. Opcode DD -> illegal=1, imm_len=0.

Source files
------------

// File: rtl/instr_fetch.sv
// SM83 fetch stage: reads instruction bytes over a byte-wide memory handshake,
// assembles opcode/CB-prefix/operands and hands them to the decoder.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic [15:0] imm,
  output logic [1:0]  imm_len,
  output logic        illegal,
  output logic [15:0] instr_pc,
  output logic [15:0] next_pc,
  output logic [2:0]  dbg_state
);

  // Handshakes: a memory byte transfers on a rising edge where mem_rd && mem_ack
  // (unless pc_load is high); an instruction transfers where instr_valid && instr_ready.
  typedef enum logic [2:0] {
    ST_OPC  = 3'd0,
    ST_CBOP = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_next_pc;
  logic [15:0] r_instr_pc;
  logic [15:0] r_imm;
  logic [7:0]  r_opcode;
  logic [1:0]  r_imm_len;
  logic        r_cb;
  logic        r_illegal;
  logic [15:0] w_pc_inc;
  logic        w_cap;
  logic [1:0]  w_len;
  logic        w_illegal;
  logic        w_is_cb;

  // Operand byte count of an unprefixed opcode.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:                      op_len = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:        op_len = 2'd2;
      default:                                          op_len = 2'd0;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [7:0] op);
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: op_illegal = 1'b1;
      default:                           op_illegal = 1'b0;
    endcase
  endfunction

  assign w_pc_inc  = r_pc + 16'd1;
  assign w_len     = op_len(mem_rdata);
  assign w_illegal = op_illegal(mem_rdata);
  assign w_is_cb   = (mem_rdata == 8'hCB);

  // Halt only blocks starting a new instruction; reset keeps the bus idle.
  assign mem_rd = !rst && (((r_state == ST_OPC) && !halt) ||
                           (r_state == ST_CBOP) || (r_state == ST_LO) ||
                           (r_state == ST_HI));
  assign w_cap  = mem_rd && mem_ack && !pc_load;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_OPC: begin
        if (w_cap) begin
          if (w_is_cb)             w_next = ST_CBOP;
          else if (w_len != 2'd0)  w_next = ST_LO;
          else                     w_next = ST_HOLD;
        end
      end
      ST_CBOP: if (w_cap) w_next = ST_HOLD;
      ST_LO:   if (w_cap) w_next = (r_imm_len == 2'd2) ? ST_HI : ST_HOLD;
      ST_HI:   if (w_cap) w_next = ST_HOLD;
      ST_HOLD: if (instr_ready) w_next = ST_OPC;
      default: w_next = ST_OPC;
    endcase
    if (pc_load) w_next = ST_OPC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OPC;
      r_pc       <= RESET_PC;
      r_next_pc  <= RESET_PC;
      r_instr_pc <= RESET_PC;
      r_imm      <= 16'h0000;
      r_opcode   <= 8'h00;
      r_imm_len  <= 2'd0;
      r_cb       <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (pc_load) begin
        r_pc <= pc_load_val;
      end else if (w_cap) begin
        r_pc      <= w_pc_inc;
        r_next_pc <= w_pc_inc;
        case (r_state)
          ST_OPC: begin
            r_instr_pc <= r_pc;
            r_opcode   <= mem_rdata;
            r_cb       <= 1'b0;
            r_imm      <= 16'h0000;
            r_imm_len  <= w_is_cb ? 2'd0 : w_len;
            r_illegal  <= w_illegal;
          end
          ST_CBOP: begin
            r_opcode  <= mem_rdata;
            r_cb      <= 1'b1;
            r_imm_len <= 2'd0;
          end
          ST_LO:   r_imm[7:0]  <= mem_rdata;
          ST_HI:   r_imm[15:8] <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign mem_addr    = r_pc;
  assign instr_valid = (r_state == ST_HOLD);
  assign opcode      = r_opcode;
  assign cb_prefix   = r_cb;
  assign imm         = r_imm;
  assign imm_len     = r_imm_len;
  assign illegal     = r_illegal;
  assign instr_pc    = r_instr_pc;
  assign next_pc     = r_next_pc;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with configurable wait states, an instruction
// scoreboard, a table of single-instruction vectors and hand-written corner sequences.
module tb_instr_fetch;

  localparam int W = 60;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic [15:0] imm;
  logic [1:0]  imm_len;
  logic        illegal;
  logic [15:0] instr_pc;
  logic [15:0] next_pc;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [0:65535];
  int          wait_cfg;
  int          r_wait;
  int          cyc;
  int          total;
  int          bad;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  e_op;
    logic        e_cb;
    logic [15:0] e_imm;
    logic [1:0]  e_len;
    logic        e_ill;
    logic [15:0] e_npc;
  } vec_t;

  vec_t vecs[16];

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .cb_prefix(cb_prefix), .imm(imm), .imm_len(imm_len),
    .illegal(illegal), .instr_pc(instr_pc), .next_pc(next_pc), .dbg_state(dbg_state)
  );

  // Clock / reset-independent infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack after wait_cfg stall cycles, restart on redirect.
  assign mem_ack   = mem_rd && (r_wait >= wait_cfg);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (rst || !mem_rd || mem_ack || pc_load) r_wait <= 0;
    else r_wait <= r_wait + 1;
  end

  // Scoreboard: pop on every accepted instruction.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (!rst && instr_valid && instr_ready && !pc_load) begin
      act = {opcode, cb_prefix, imm, imm_len, illegal, instr_pc, next_pc};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_instr at pc=%h got=%h", instr_pc, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL instr pc=%h got=%h exp=%h", instr_pc, act, e);
        end
      end
    end
  end

  // Address/request must hold steady while a read waits for ack.
  logic        prev_wait;
  logic [15:0] prev_addr;
  always @(negedge clk) begin
    if (!rst && prev_wait && mem_rd) begin
      total++;
      if (mem_addr !== prev_addr) begin
        bad++;
        $display("FAIL addr_stable got=%h exp=%h", mem_addr, prev_addr);
      end
    end
    prev_wait = mem_rd && !mem_ack && !pc_load && !rst;
    prev_addr = mem_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] op, input logic cb, input logic [15:0] im,
                          input logic [1:0] len, input logic ill,
                          input logic [15:0] ipc, input logic [15:0] npc);
    exp_q.push_back({op, cb, im, len, ill, ipc, npc});
  endtask

  task automatic redirect(input logic [15:0] addr);
    pc_load = 1'b1;
    pc_load_val = addr;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic accept_one(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 100) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout valid=0 exp=1", name);
    end else begin
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
  endtask

  // Redirect to addr and measure cycles until valid plus cycles spent reading addr.
  task automatic measure(input string name, input logic [15:0] addr,
                         input int exp_lat, input int exp_rd);
    int t0;
    int rd_cnt;
    int n;
    redirect(addr);
    t0 = cyc;
    rd_cnt = 0;
    n = 0;
    while (!instr_valid && n < 100) begin
      if (mem_rd && mem_addr == addr) rd_cnt++;
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
    check({name, "_addr_cycles"}, 64'(rd_cnt), 64'(exp_rd));
  endtask

  function automatic vec_t mk(input logic [15:0] addr, input logic [7:0] b0, b1, b2,
                              input logic [7:0] op, input logic cb, input logic [15:0] im,
                              input logic [1:0] len, input logic ill, input logic [15:0] npc);
    vec_t v;
    v.addr = addr; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.e_op = op; v.e_cb = cb; v.e_imm = im; v.e_len = len; v.e_ill = ill; v.e_npc = npc;
    return v;
  endfunction

  initial begin
    int n;
    int seen_rd;
    logic [15:0] a;

    vecs[0]  = mk(16'h0300, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0301);
    vecs[1]  = mk(16'h0310, 8'h3E, 8'h42, 8'h00, 8'h3E, 1'b0, 16'h0042, 2'd1, 1'b0, 16'h0312);
    vecs[2]  = mk(16'h0320, 8'hC3, 8'h34, 8'h12, 8'hC3, 1'b0, 16'h1234, 2'd2, 1'b0, 16'h0323);
    vecs[3]  = mk(16'h0100, 8'hCB, 8'h37, 8'h00, 8'h37, 1'b1, 16'h0000, 2'd0, 1'b0, 16'h0102);
    vecs[4]  = mk(16'h0330, 8'hDD, 8'h11, 8'h22, 8'hDD, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h0331);
    vecs[5]  = mk(16'h0340, 8'hE0, 8'h80, 8'h00, 8'hE0, 1'b0, 16'h0080, 2'd1, 1'b0, 16'h0342);
    vecs[6]  = mk(16'h0350, 8'h01, 8'hCD, 8'hAB, 8'h01, 1'b0, 16'hABCD, 2'd2, 1'b0, 16'h0353);
    vecs[7]  = mk(16'h0360, 8'hFD, 8'h00, 8'h00, 8'hFD, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h0361);
    vecs[8]  = mk(16'h0370, 8'h08, 8'h11, 8'h22, 8'h08, 1'b0, 16'h2211, 2'd2, 1'b0, 16'h0373);
    vecs[9]  = mk(16'h0380, 8'hCB, 8'h7C, 8'h00, 8'h7C, 1'b1, 16'h0000, 2'd0, 1'b0, 16'h0382);
    vecs[10] = mk(16'h0390, 8'hE8, 8'hFE, 8'h00, 8'hE8, 1'b0, 16'h00FE, 2'd1, 1'b0, 16'h0392);
    vecs[11] = mk(16'h03A0, 8'h18, 8'h05, 8'h00, 8'h18, 1'b0, 16'h0005, 2'd1, 1'b0, 16'h03A2);
    vecs[12] = mk(16'h03B0, 8'hD3, 8'h00, 8'h00, 8'hD3, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h03B1);
    vecs[13] = mk(16'h03C0, 8'hC6, 8'h10, 8'h00, 8'hC6, 1'b0, 16'h0010, 2'd1, 1'b0, 16'h03C2);
    vecs[14] = mk(16'h03D0, 8'hFA, 8'h00, 8'hC0, 8'hFA, 1'b0, 16'hC000, 2'd2, 1'b0, 16'h03D3);
    vecs[15] = mk(16'hFFFE, 8'hCD, 8'h56, 8'h78, 8'hCD, 1'b0, 16'h7856, 2'd2, 1'b0, 16'h0001);

    total = 0; bad = 0; cyc = 0; wait_cfg = 0;
    rst = 1'b1; pc_load = 1'b0; pc_load_val = 16'h0000; halt = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h3E; mem[2] = 8'h42;
    mem[3] = 8'hC3; mem[4] = 8'h34; mem[5] = 8'h12;

    // Reset state
    tick(); tick();
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_rd", 64'(mem_rd), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'h0000);
    check("rst_fields", 64'({opcode, cb_prefix, imm, imm_len, illegal}), 64'd0);
    check("rst_pcs", 64'({instr_pc, next_pc}), 64'h0);
    rst = 1'b0;

    // Test-plan program, zero wait
    push_exp(8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0001);
    push_exp(8'h3E, 1'b0, 16'h0042, 2'd1, 1'b0, 16'h0001, 16'h0003);
    push_exp(8'hC3, 1'b0, 16'h1234, 2'd2, 1'b0, 16'h0003, 16'h0006);
    accept_one("prog0_a"); accept_one("prog0_b"); accept_one("prog0_c");

    push_exp(8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0001);
    measure("lat_1byte", 16'h0000, 1, 1);
    accept_one("lat_1byte");
    push_exp(8'hC3, 1'b0, 16'h1234, 2'd2, 1'b0, 16'h0003, 16'h0006);
    measure("lat_3byte", 16'h0003, 3, 1);
    accept_one("lat_3byte");

    // Same program with two wait cycles per byte
    wait_cfg = 2;
    redirect(16'h0000);
    push_exp(8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0001);
    push_exp(8'h3E, 1'b0, 16'h0042, 2'd1, 1'b0, 16'h0001, 16'h0003);
    push_exp(8'hC3, 1'b0, 16'h1234, 2'd2, 1'b0, 16'h0003, 16'h0006);
    accept_one("prog2_a"); accept_one("prog2_b"); accept_one("prog2_c");
    push_exp(8'hC3, 1'b0, 16'h1234, 2'd2, 1'b0, 16'h0003, 16'h0006);
    measure("lat_wait", 16'h0003, 9, 3);
    accept_one("lat_wait");

    // Redirect exactly when the high operand byte is acked
    redirect(16'h0003);
    n = 0;
    while (!(mem_rd && mem_addr == 16'h0005 && mem_ack) && n < 100) begin tick(); n++; end
    check("hi_wait_reached", 64'(mem_rd && mem_addr == 16'h0005 && mem_ack), 64'd1);
    pc_load = 1'b1; pc_load_val = 16'h0200;
    tick();
    pc_load = 1'b0;
    check("redir_hi_addr", 64'(mem_addr), 64'h0200);
    check("redir_hi_rd", 64'(mem_rd), 64'd1);
    check("redir_hi_valid", 64'(instr_valid), 64'd0);
    push_exp(8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0200, 16'h0201);
    accept_one("after_redir_hi");

    // Redirect while holding, with instr_ready high in the same cycle
    wait_cfg = 0;
    redirect(16'h0001);
    n = 0;
    while (!instr_valid && n < 100) begin tick(); n++; end
    pc_load = 1'b1; pc_load_val = 16'h0400; instr_ready = 1'b1;
    tick();
    pc_load = 1'b0; instr_ready = 1'b0;
    check("redir_hold_valid", 64'(instr_valid), 64'd0);
    check("redir_hold_addr", 64'(mem_addr), 64'h0400);
    push_exp(8'h00, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0400, 16'h0401);
    accept_one("after_redir_hold");

    // Halt in OPC keeps the bus idle
    mem[16'h0500] = 8'h06; mem[16'h0501] = 8'h77;
    halt = 1'b1;
    redirect(16'h0500);
    seen_rd = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd || instr_valid) seen_rd++;
      tick();
    end
    check("halt_idle", 64'(seen_rd), 64'd0);
    check("halt_pc", 64'(mem_addr), 64'h0500);
    halt = 1'b0;
    push_exp(8'h06, 1'b0, 16'h0077, 2'd1, 1'b0, 16'h0500, 16'h0502);
    accept_one("halt_resume");

    // Halt rising while an opcode read waits for ack
    wait_cfg = 2;
    redirect(16'h0500);
    halt = 1'b1;
    #1;
    check("halt_drop_rd", 64'(mem_rd), 64'd0);
    repeat (5) tick();
    check("halt_wait_pc", 64'(mem_addr), 64'h0500);
    check("halt_wait_valid", 64'(instr_valid), 64'd0);
    halt = 1'b0;
    push_exp(8'h06, 1'b0, 16'h0077, 2'd1, 1'b0, 16'h0500, 16'h0502);
    accept_one("halt_wait_resume");

    // Halt during an operand read: the instruction still completes
    wait_cfg = 1;
    mem[16'h0510] = 8'hC3; mem[16'h0511] = 8'hBB; mem[16'h0512] = 8'hAA;
    redirect(16'h0510);
    n = 0;
    while (!(mem_rd && mem_addr == 16'h0511) && n < 100) begin tick(); n++; end
    halt = 1'b1;
    push_exp(8'hC3, 1'b0, 16'hAABB, 2'd2, 1'b0, 16'h0510, 16'h0513);
    accept_one("halt_in_lo");
    repeat (3) tick();
    check("halt_after_lo_rd", 64'(mem_rd), 64'd0);
    halt = 1'b0;

    // Table of single-instruction vectors with random wait states
    for (int i = 0; i < 16; i++) begin
      a = vecs[i].addr;
      mem[a] = vecs[i].b0; a = a + 16'd1;
      mem[a] = vecs[i].b1; a = a + 16'd1;
      mem[a] = vecs[i].b2;
      wait_cfg = $urandom_range(0, 2);
      redirect(vecs[i].addr);
      push_exp(vecs[i].e_op, vecs[i].e_cb, vecs[i].e_imm, vecs[i].e_len, vecs[i].e_ill,
               vecs[i].addr, vecs[i].e_npc);
      accept_one($sformatf("vec%0d", i));
    end

    repeat (4) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
